// File: rtl/branch_predictor_pkg.sv
// Shared constants for the tournament branch predictor: table geometry and
// 2-bit counter / chooser encodings, plus the saturating step helper.
package branch_predictor_pkg;

  localparam int PRED_TABLE_BIT = 6;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_e;

  // Chooser MSB set selects the gshare table.
  typedef enum logic [1:0] {
    CH_LOCAL_STRONG  = 2'd0,
    CH_LOCAL_WEAK    = 2'd1,
    CH_GLOBAL_WEAK   = 2'd2,
    CH_GLOBAL_STRONG = 2'd3
  } chooser_e;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == CNT_ST)  ? c : c + 2'd1;
    else    return (c == CNT_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_pred_counter_table.sv
// 2**PTB x 2-bit saturating counter array: one combinational lookup port and
// one inc/dec port whose pre-update value is exposed for the chooser rule.
module pred_counter_table
  import branch_predictor_pkg::*;
#(
  parameter int         PTB      = PRED_TABLE_BIT,
  parameter logic [1:0] CNT_INIT = CNT_WNT
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic [PTB-1:0] rd_ind,
  output logic [1:0]     rd_cnt,
  input  logic [PTB-1:0] wr_ind,
  input  logic           inc,
  input  logic           dec,
  output logic [1:0]     wr_cnt
);

  localparam int DEPTH = 1 << PTB;

  logic [1:0] cnt [DEPTH];

  assign rd_cnt = cnt[rd_ind];
  assign wr_cnt = cnt[wr_ind];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= CNT_INIT;
    end else if (inc ^ dec) begin
      cnt[wr_ind] <= sat_step(cnt[wr_ind], inc);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tournament (local / gshare) direction predictor: zero-cycle lookup,
// speculative + committed global history, commit-time training and stats.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         PTB      = PRED_TABLE_BIT,
  parameter logic [1:0] CNT_INIT = CNT_WNT
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           rdy_in,
  input  logic           query_valid,
  input  logic [31:0]    query_pc,
  output logic           pred_out,
  output logic [PTB-1:0] g_ind_out,
  output logic [PTB-1:0] l_ind_out,
  input  logic           br_ready,
  input  logic           br_res,
  input  logic           br_correct,
  input  logic [PTB-1:0] br_g_ind,
  input  logic [PTB-1:0] br_l_ind,
  input  logic           clear_in,
  output logic [31:0]    stat_br_out,
  output logic [31:0]    stat_miss_out
);

  logic [PTB-1:0] spec_ghr, commit_ghr, commit_ghr_nxt;
  logic [1:0]     g_rd, l_rd, c_rd, g_wr, l_wr, c_wr_unused;
  logic           upd, g_hit, l_hit, ch_inc, ch_dec;
  logic           unused_pc;

  assign unused_pc = ^{query_pc[31:PTB+2], query_pc[1:0], c_wr_unused};

  assign l_ind_out = query_pc[PTB+1:2];
  assign g_ind_out = query_pc[PTB+1:2] ^ spec_ghr;
  assign pred_out  = c_rd[1] ? g_rd[1] : l_rd[1];

  assign upd   = br_ready & rdy_in;
  assign g_hit = (g_wr[1] == br_res);
  assign l_hit = (l_wr[1] == br_res);
  // Chooser only moves when exactly one component was right.
  assign ch_inc = upd & g_hit & ~l_hit;
  assign ch_dec = upd & l_hit & ~g_hit;

  pred_counter_table #(.PTB(PTB), .CNT_INIT(CNT_INIT)) u_gtab (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rd_ind(g_ind_out), .rd_cnt(g_rd),
    .wr_ind(br_g_ind), .inc(upd & br_res), .dec(upd & ~br_res), .wr_cnt(g_wr)
  );

  pred_counter_table #(.PTB(PTB), .CNT_INIT(CNT_INIT)) u_ltab (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rd_ind(l_ind_out), .rd_cnt(l_rd),
    .wr_ind(br_l_ind), .inc(upd & br_res), .dec(upd & ~br_res), .wr_cnt(l_wr)
  );

  pred_counter_table #(.PTB(PTB), .CNT_INIT(CH_LOCAL_WEAK)) u_chooser (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rd_ind(l_ind_out), .rd_cnt(c_rd),
    .wr_ind(br_l_ind), .inc(ch_inc), .dec(ch_dec), .wr_cnt(c_wr_unused)
  );

  assign commit_ghr_nxt = upd ? {commit_ghr[PTB-2:0], br_res} : commit_ghr;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      spec_ghr      <= '0;
      commit_ghr    <= '0;
      stat_br_out   <= '0;
      stat_miss_out <= '0;
    end else if (rdy_in) begin
      commit_ghr <= commit_ghr_nxt;
      // A flush restores history from the commit side, dropping any same-cycle query.
      if (clear_in)         spec_ghr <= commit_ghr_nxt;
      else if (query_valid) spec_ghr <= {spec_ghr[PTB-2:0], pred_out};
      if (br_ready) begin
        stat_br_out <= stat_br_out + 32'd1;
        if (!br_correct) stat_miss_out <= stat_miss_out + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against an integer-array reference model of the predictor.
module tb_branch_predictor;
  localparam int PTB = 6;
  localparam int N   = 1 << PTB;

  logic           clk_in = 1'b0;
  logic           rst_n_in, rdy_in, query_valid, br_ready, br_res, br_correct, clear_in;
  logic [31:0]    query_pc;
  logic [PTB-1:0] br_g_ind, br_l_ind, g_ind_out, l_ind_out;
  logic           pred_out;
  logic [31:0]    stat_br_out, stat_miss_out;

  branch_predictor #(.PTB(PTB), .CNT_INIT(2'b01)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .query_valid(query_valid), .query_pc(query_pc),
    .pred_out(pred_out), .g_ind_out(g_ind_out), .l_ind_out(l_ind_out),
    .br_ready(br_ready), .br_res(br_res), .br_correct(br_correct),
    .br_g_ind(br_g_ind), .br_l_ind(br_l_ind), .clear_in(clear_in),
    .stat_br_out(stat_br_out), .stat_miss_out(stat_miss_out)
  );

  always #5 clk_in = ~clk_in;

  int errs = 0, checks = 0;
  int m_g[N], m_l[N], m_c[N];
  int m_spec, m_commit;
  int unsigned m_br, m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin m_g[i] = 1; m_l[i] = 1; m_c[i] = 1; end
    m_spec = 0; m_commit = 0; m_br = 0; m_miss = 0;
  endfunction

  function automatic int m_lind();
    return (query_pc / 4) % N;
  endfunction

  function automatic int m_gind();
    return m_lind() ^ m_spec;
  endfunction

  function automatic int m_pred();
    if (m_c[m_lind()] >= 2) return (m_g[m_gind()] >= 2) ? 1 : 0;
    return (m_l[m_lind()] >= 2) ? 1 : 0;
  endfunction

  function automatic int clamp3(int v);
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  // Reference next-state from the commit / history rules, all in plain integers.
  function automatic void m_step();
    int p, dir, go, lo;
    p = m_pred();
    if (!rdy_in) return;
    if (br_ready) begin
      dir = br_res ? 1 : -1;
      go  = (m_g[br_g_ind] >= 2) ? 1 : 0;
      lo  = (m_l[br_l_ind] >= 2) ? 1 : 0;
      if (go == br_res && lo != br_res) m_c[br_l_ind] = clamp3(m_c[br_l_ind] + 1);
      if (lo == br_res && go != br_res) m_c[br_l_ind] = clamp3(m_c[br_l_ind] - 1);
      m_g[br_g_ind] = clamp3(m_g[br_g_ind] + dir);
      m_l[br_l_ind] = clamp3(m_l[br_l_ind] + dir);
      m_commit = (m_commit * 2 + br_res) % N;
      m_br++;
      if (!br_correct) m_miss++;
    end
    if (clear_in)         m_spec = m_commit;
    else if (query_valid) m_spec = (m_spec * 2 + p) % N;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".pred"},  {31'd0, pred_out}, m_pred());
    chk({tag, ".l_ind"}, {26'd0, l_ind_out}, m_lind());
    chk({tag, ".g_ind"}, {26'd0, g_ind_out}, m_gind());
    chk({tag, ".br"},    stat_br_out, m_br);
    chk({tag, ".miss"},  stat_miss_out, m_miss);
  endtask

  task automatic cycle(input string tag);
    @(negedge clk_in);
    check_outs(tag);
    m_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; query_valid = 1'b0; br_ready = 1'b0; clear_in = 1'b0;
    br_res = 1'b0; br_correct = 1'b1; br_g_ind = '0; br_l_ind = '0;
  endtask

  task automatic commit(input string tag, input int g, input int l, input bit res, input bit ok);
    idle();
    br_ready = 1'b1; br_res = res; br_correct = ok;
    br_g_ind = g[PTB-1:0]; br_l_ind = l[PTB-1:0];
    cycle(tag);
    idle();
  endtask

  initial begin
    rst_n_in = 1'b0;
    idle();
    query_pc = 32'h100;
    m_reset();
    #2;
    chk("rst.pred", {31'd0, pred_out}, 32'd0);
    chk("rst.l_ind", {26'd0, l_ind_out}, 32'd0);
    chk("rst.g_ind", {26'd0, g_ind_out}, 32'd0);
    chk("rst.br", stat_br_out, 32'd0);
    chk("rst.miss", stat_miss_out, 32'd0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // Three taken commits to entry 0.
    for (int i = 0; i < 3; i++) commit("t2", 0, 0, 1'b1, 1'b1);
    query_pc = 32'h0;
    cycle("t2.look");
    chk("t2.pred_taken", {31'd0, pred_out}, 32'd1);

    // Saturation on local entry 5.
    for (int i = 0; i < 5; i++) commit("t3", 5, 5, 1'b1, 1'b1);
    commit("t3n", 5, 5, 1'b0, 1'b0);
    query_pc = 32'h14;
    cycle("t3.look");
    chk("t3.pred_sat", {31'd0, pred_out}, 32'd1);

    // Build gtab[9]=3, ltab[9]=0, then one commit moves chooser[9] to global.
    for (int i = 0; i < 3; i++) commit("t4a", 9, 30, 1'b1, 1'b1);
    commit("t4b", 40, 9, 1'b0, 1'b1);
    commit("t4c", 9, 9, 1'b1, 1'b0);
    query_pc = 32'h24;
    cycle("t4.look");
    chk("t4.pred_global", {31'd0, pred_out}, 32'd1);

    // Speculative shifts, then flush with same-cycle commit.
    idle(); query_valid = 1'b1;
    cycle("t5.q0");
    cycle("t5.q1");
    idle(); br_ready = 1'b1; br_res = 1'b0; br_correct = 1'b0; clear_in = 1'b1;
    query_valid = 1'b1; br_g_ind = 6'd3; br_l_ind = 6'd4;
    cycle("t5.clr");
    idle();
    cycle("t5.after");

    // Stalled cycle with everything asserted.
    br_ready = 1'b1; clear_in = 1'b1; query_valid = 1'b1; br_res = 1'b1; br_correct = 1'b0;
    rdy_in = 1'b0;
    cycle("t6.stall");
    idle();
    cycle("t6.after");

    // Random traffic over a narrow pc window to force index reuse and aliasing.
    for (int i = 0; i < 400; i++) begin
      rdy_in      = ($urandom_range(9) != 0);
      query_valid = $urandom_range(1);
      query_pc    = {$urandom} & 32'h0000_003C;
      br_ready    = $urandom_range(1);
      br_res      = $urandom_range(1);
      br_correct  = $urandom_range(3) != 0;
      br_g_ind    = PTB'($urandom_range(15));
      br_l_ind    = PTB'($urandom_range(15));
      clear_in    = ($urandom_range(7) == 0);
      cycle("rnd");
    end

    // Asynchronous reset between edges.
    idle();
    query_pc = 32'h24;
    rst_n_in = 1'b0;
    #2;
    m_reset();
    check_outs("arst");
    chk("arst.pred0", {31'd0, pred_out}, 32'd0);
    #1;
    rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) commit("post", i, i + 1, 1'b1, 1'b0);
    cycle("post.look");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
